// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared processor types and defaults (load FSM states, NOP word).
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int c_DATA_W = 32;
    localparam logic [c_DATA_W-1:0] c_NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pm_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_mem_ram.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem_ram
// Brief    : Simple dual-port RAM, synchronous write, registered read, no reset.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem_ram
    import proc_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read register only advances on a read so the last result holds.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : prog_mem
// Brief    : Loadable instruction memory with streaming load port and
//            registered, range-checked fetch port.
// Revision : 1.0 - initial release
// ============================================================================
module prog_mem
    import proc_pkg::*;
#(
    parameter int                DATA_W   = c_DATA_W,
    parameter int                DEPTH    = 128,
    parameter int                ADDR_W   = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_NOP_WORD)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic [ADDR_W:0]   prog_len,
    input  logic              fetch_req,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic              fetch_fault
);

    localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W+1)'(DEPTH-1);
    localparam logic [ADDR_W:0] c_ONE      = (ADDR_W+1)'(1);

    pm_state_t         r_state;
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_prog_len;
    logic              r_hit;
    logic              r_valid;
    logic              r_fault;

    logic              w_accept;
    logic              w_last_word;
    logic              w_fetch_ok;
    logic [DATA_W-1:0] w_ram_q;

    assign w_accept    = load_valid && (r_state == ST_LOAD);
    assign w_last_word = load_last || (r_wptr == c_LAST_IDX);
    // Full 32-bit compare so nonzero upper pc bits count as out of range.
    assign w_fetch_ok  = (r_state == ST_RUN) && (pc < 32'(r_prog_len));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wptr     <= '0;
            r_prog_len <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (load_start) begin
                        r_state <= ST_LOAD;
                        r_wptr  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_wptr <= r_wptr + c_ONE;
                        if (w_last_word) begin
                            r_state    <= ST_RUN;
                            r_prog_len <= r_wptr + c_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Hit/fault flags are aligned with the RAM read register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= fetch_req;
            if (fetch_req) begin
                r_hit   <= w_fetch_ok;
                r_fault <= !w_fetch_ok;
            end
        end
    end

    prog_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (w_accept),
        .wr_addr (r_wptr[ADDR_W-1:0]),
        .wr_data (load_data),
        .rd_en   (fetch_req && w_fetch_ok),
        .rd_addr (pc[ADDR_W-1:0]),
        .rd_data (w_ram_q)
    );

    assign load_ready  = (r_state == ST_LOAD);
    assign load_busy   = (r_state == ST_LOAD);
    assign prog_len    = r_prog_len;
    assign instr_out   = r_hit ? w_ram_q : NOP_WORD;
    assign instr_valid = r_valid;
    assign fetch_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mem
// Brief    : Randomised self-checking bench for prog_mem against a
//            program-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_prog_mem;
    import proc_pkg::*;

    localparam int          DEPTH  = 128;
    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 7;
    localparam logic [31:0] NOP    = 32'h0;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic              load_busy;
    logic [ADDR_W:0]   prog_len;
    logic              fetch_req = 1'b0;
    logic [31:0]       pc = '0;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              fetch_fault;

    always #5 clock = ~clock;

    prog_mem #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_WORD (NOP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_busy   (load_busy),
        .prog_len    (prog_len),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .fetch_fault (fetch_fault)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the visible program and whether it is runnable.
    logic [31:0] m_mem [DEPTH];
    int          m_len = 0;
    bit          m_run = 1'b0;
    logic [31:0] m_last_instr = NOP;
    bit          m_last_fault = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit exp_ok(input logic [31:0] p);
        return m_run && (p < 32'(m_len));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        return exp_ok(p) ? m_mem[p[ADDR_W-1:0]] : NOP;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
        #2;
        m_len = 0; m_run = 1'b0; m_last_instr = NOP; m_last_fault = 1'b0;
        check("rst_ready", load_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_prog_len", prog_len, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr_out", instr_out, NOP);
        check("rst_fault", fetch_fault, 0);
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_run = 1'b0;
        check("start_ready", load_ready, 1);
        check("start_busy", load_busy, 1);
    endtask

    // Offers words in order; an offered word is taken whenever valid is high.
    task automatic feed(input logic [31:0] words[$], input bit use_last,
                        input bit rnd_valid, input bit complete);
        int i = 0;
        while (i < words.size()) begin
            load_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            load_data  = words[i];
            load_last  = use_last && (i == words.size() - 1);
            check("load_ready_during", load_ready, 1);
            tick();
            if (load_valid) begin
                m_mem[i] = words[i];
                i++;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (complete) begin
            m_len = words.size();
            m_run = 1'b1;
            check("end_ready", load_ready, 0);
            check("end_busy", load_busy, 0);
            check("prog_len", prog_len, 64'(m_len));
        end
    endtask

    task automatic fetch_seq(input logic [31:0] pcs[$]);
        fetch_req = 1'b1;
        foreach (pcs[i]) begin
            pc = pcs[i];
            tick();
            m_last_instr = exp_instr(pcs[i]);
            m_last_fault = !exp_ok(pcs[i]);
            check("fetch_valid", instr_valid, 1);
            check("fetch_instr", instr_out, m_last_instr);
            check("fetch_fault", fetch_fault, m_last_fault);
        end
        fetch_req = 1'b0;
        pc = $urandom;
        tick();
        check("idle_valid", instr_valid, 0);
        check("idle_instr_hold", instr_out, m_last_instr);
        check("idle_fault_hold", fetch_fault, m_last_fault);
    endtask

    task automatic rand_words(input int n, output logic [31:0] q[$]);
        q = {};
        for (int k = 0; k < n; k++) q.push_back($urandom);
    endtask

    initial begin
        logic [31:0] wq[$];
        logic [31:0] pq[$];
        logic [31:0] exp_w;

        apply_reset();

        // Fetch before any program exists.
        fetch_seq('{32'd0});

        // Fixed three-word program.
        start_load();
        feed('{32'h58120000, 32'h34A00005, 32'h04E94000}, 1'b1, 1'b0, 1'b1);
        fetch_seq('{32'd0, 32'd1, 32'd2, 32'd3});

        // Fill the whole memory without load_last, then offer one more word.
        rand_words(DEPTH, wq);
        start_load();
        feed(wq, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1;
        load_data  = $urandom;
        tick();
        load_valid = 1'b0;
        check("full_extra_ready", load_ready, 0);
        check("full_extra_len", prog_len, 64'(DEPTH));
        fetch_seq('{32'd127, 32'd0, 32'd128, 32'h8000_0001});

        // Five words with a randomly gapped valid.
        rand_words(5, wq);
        start_load();
        feed(wq, 1'b1, 1'b1, 1'b1);
        fetch_seq('{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5});

        // Reset after two of four words.
        rand_words(4, wq);
        start_load();
        feed(wq[0:1], 1'b0, 1'b0, 1'b0);
        apply_reset();
        fetch_seq('{32'd0});

        // Reload from RUN, with fetches on the start cycle and during LOAD.
        rand_words(4, wq);
        start_load();
        feed(wq, 1'b1, 1'b0, 1'b1);
        exp_w      = exp_instr(32'd1);
        fetch_req  = 1'b1;
        pc         = 32'd1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        m_run      = 1'b0;
        pc         = 32'd0;
        check("start_cycle_fetch_instr", instr_out, exp_w);
        check("start_cycle_fetch_fault", fetch_fault, 0);
        tick();
        fetch_req  = 1'b0;
        check("load_fetch_instr", instr_out, NOP);
        check("load_fetch_fault", fetch_fault, 1);
        rand_words(2, wq);
        feed(wq, 1'b1, 1'b0, 1'b1);
        fetch_seq('{32'd1, 32'd3, 32'd0});

        // Random programs with random in/out-of-range fetches.
        for (int it = 0; it < 8; it++) begin
            rand_words($urandom_range(1, 24), wq);
            start_load();
            feed(wq, 1'b1, it[0], 1'b1);
            pq = {};
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 5) == 0) pq.push_back($urandom);
                else pq.push_back(32'($urandom_range(0, m_len + 2)));
            end
            fetch_seq(pq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/prog_mem.md
# prog_mem

Parametrised, loadable instruction memory for the processor. It replaces the hard-coded, clock-written program store with three parts: a streaming load port with a valid/ready handshake, a load state machine, and a registered fetch port with out-of-range detection. It sits between the fetch stage (PC in, instruction out) and the program-load source, either the test bench or a serial loader.

## Interface
Parameters:
- DATA_W, default 32: instruction width in bits.
- DEPTH, default 128: number of instruction words.
- ADDR_W, default $clog2(DEPTH): internal address width.
- NOP_WORD, default 0: word returned on any invalid fetch.

Ports:
- clock, input, 1: the single clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- load_start, input, 1: one-cycle pulse that requests a program load.
- load_valid, input, 1: load_data is valid this cycle.
- load_ready, output, 1: the block accepts a word this cycle.
- load_data, input, DATA_W: instruction word to store.
- load_last, input, 1: marks the final word of the program.
- load_busy, output, 1: high while in LOAD.
- prog_len, output, ADDR_W+1: number of words written by the last completed load.
- fetch_req, input, 1: fetch request.
- pc, input, 32: word index; the address is not byte-scaled.
- instr_out, output, DATA_W: fetched instruction, registered.
- instr_valid, output, 1: instr_out holds a fresh fetch result.
- fetch_fault, output, 1: the last fetch was out of range or was blocked.

## Operation
States are IDLE, LOAD and RUN. The reset state is IDLE.
- IDLE to LOAD on load_start.
- LOAD to RUN when a word is accepted with load_last=1, or when the word at address DEPTH-1 is accepted (memory full).
- RUN to LOAD on load_start. RUN can be entered from IDLE only through a load.
- load_start while in LOAD is ignored.

Load behaviour:
- On entering LOAD, the write pointer wptr is cleared to 0.
- load_ready = (state==LOAD).
- A word is accepted when load_valid && load_ready. The word is written to mem[wptr] and wptr increments by 1.
- On exit to RUN, prog_len takes the final count (1 to DEPTH).
- Extra words offered after the block is full are not accepted, because load_ready=0 in RUN.

Fetch behaviour:
- A fetch is accepted when fetch_req=1. The result appears next cycle with instr_valid=1.
- The fetch is valid only if state==RUN and pc < prog_len. Then instr_out = mem[pc] and fetch_fault=0.
- Otherwise (IDLE, LOAD, pc ≥ prog_len, or upper pc bits nonzero), instr_out = NOP_WORD and fetch_fault=1.
- With fetch_req=0, instr_valid=0 next cycle. instr_out and fetch_fault hold their previous values.

Storage:
- Memory contents are not cleared by reset. Only prog_len gates valid reads.
- A write and a read in the same cycle are impossible, because they are confined to different states.

## Timing
- Reset values: state=IDLE, wptr=0, prog_len=0, load_ready=0, load_busy=0, instr_out=NOP_WORD, instr_valid=0, fetch_fault=0.
- Fetch latency is 1 cycle, from the edge sampling pc to instr_out/instr_valid. Back-to-back fetches run at full rate.
- Load throughput is 1 word/cycle. load_ready rises the cycle after load_start and falls the cycle after the last accept.
- A fetch in the same cycle as load_start is evaluated against the pre-edge state. In RUN it returns valid data.
- If reset_n is asserted mid-load, the block returns to IDLE immediately and prog_len=0. The partial program is invisible and fetches fault.
- If a reload is interrupted by reset, the old program is lost: prog_len=0.

## Structure
- Shared package proc_pkg holds the state enum {IDLE, LOAD, RUN}, the NOP_WORD default and DATA_W=32.
- One sub-module, prog_mem_ram: a simple dual-port RAM with a synchronous write port, a synchronous registered read port and a DEPTH×DATA_W array with no reset.
- The top level holds the FSM, wptr, prog_len, the range check, and the fault/NOP mux aligned to the read register.

## Test plan
1. Reset, then fetch pc=0 → next cycle instr_valid=1, instr_out=0, fetch_fault=1.
2. Load 3 words (0x58120000, 0x34A00005, 0x04E94000) with load_last on the third → prog_len=3, state RUN. Fetch pc=0,1,2 on back-to-back cycles → those words on consecutive cycles with fetch_fault=0. Fetch pc=3 → NOP with fetch_fault=1.
3. Stream DEPTH=128 words with load_last never asserted → load_ready falls after word 127 is accepted, prog_len=128. The 129th offered word is not accepted. Fetch pc=127 → the last word.
4. Toggle load_valid randomly during a 5-word load → exactly 5 writes occur, the contents match in order, and prog_len=5.
5. Assert reset_n low after 2 of 4 words have loaded → state IDLE and prog_len=0. Fetch pc=0 → NOP with fetch_fault=1.
6. In RUN with a 4-word program, pulse load_start, load 2 new words → prog_len=2. Fetch pc=1 → the new word. Fetch pc=3 → fault. A fetch issued during LOAD → fault.
